apb_mig_bridge: RTL and testbench

//  APB slave that turns single APB transfers into Xilinx MIG UI (native app_*) commands. Data width generalised:
//  APB_DATA_W lanes are packed into one APP_DATA_W MIG beat, with byte masking from pstrb.

---
 rtl/apb_mig_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_apb_mig_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mig_bridge.sv
// apb_mig_bridge
//   APB slave that turns single APB transfers into Xilinx MIG UI (app_*) commands.
//   One APB word is placed in its lane of one APP_DATA_W MIG beat. Writes replicate
//   pwdata into every lane and mask all bytes outside the addressed lane. Reads
//   return the addressed lane of the beat. Calibration, address range/alignment and
//   MIG response timeouts are reported through pslverr_o. Runs on the MIG ui_clk.
//
// Ports
//   pclk_i, preset_i                 clock (MIG ui_clk), async active-high reset
//   paddr_i/pwdata_i/pstrb_i         APB address, write data, write strobes
//   pwrite_i/psel_i/penable_i        APB controls
//   prdata_o/pready_o/pslverr_o      APB response (pready_o high for one cycle)
//   init_calib_complete_i            MIG calibration done
//   app_addr_o/app_cmd_o/app_en_o    MIG command channel, app_rdy_i accepts
//   app_wdf_data_o/app_wdf_mask_o    MIG write data / byte mask (1 = byte not written)
//   app_wdf_wren_o/app_wdf_end_o     MIG write-data valid (single-beat, end == wren)
//   app_wdf_rdy_i                    MIG write-data accept
//   app_rd_data_i/app_rd_data_valid_i MIG read data return, one beat per read command
module apb_mig_bridge #(
  parameter int APB_ADDR_W     = 32,
  parameter int APB_DATA_W     = 32,
  parameter int APP_ADDR_W     = 28,
  parameter int APP_DATA_W     = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic [APB_ADDR_W-1:0]   paddr_i,
  input  logic [APB_DATA_W-1:0]   pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [APB_DATA_W/8-1:0] pstrb_i,
  output logic [APB_DATA_W-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic                    init_calib_complete_i,
  output logic [APP_ADDR_W-1:0]   app_addr_o,
  output logic [2:0]              app_cmd_o,
  output logic                    app_en_o,
  input  logic                    app_rdy_i,
  output logic [APP_DATA_W-1:0]   app_wdf_data_o,
  output logic [APP_DATA_W/8-1:0] app_wdf_mask_o,
  output logic                    app_wdf_wren_o,
  output logic                    app_wdf_end_o,
  input  logic                    app_wdf_rdy_i,
  input  logic [APP_DATA_W-1:0]   app_rd_data_i,
  input  logic                    app_rd_data_valid_i
);

  localparam int APB_BYTES = APB_DATA_W / 8;
  localparam int APP_BYTES = APP_DATA_W / 8;
  localparam int APB_LSB   = $clog2(APB_BYTES);
  localparam int LANES     = APP_DATA_W / APB_DATA_W;
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] CMD_WR   = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [3:0] DROP_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR, S_RD_CMD, S_RD_WAIT, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [APB_ADDR_W-1:0]   paddr_q;
  logic [APB_DATA_W-1:0]   pwdata_q;
  logic [APB_BYTES-1:0]    pstrb_q;
  logic                    pwrite_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              drop_q;   // read beats still owed by MIG for timed-out reads
  logic                    err_q;

  logic [LANE_W-1:0]       lane;
  logic                    check_err, tmo, beat_ok, lost_read, discard;
  logic                    en_done, wren_done, resp_err, issue;
  logic [APP_BYTES-1:0]    mask_c;

  assign lane = (LANES > 1) ? LANE_W'(paddr_q >> APB_LSB) : '0;

  assign check_err = !init_calib_complete_i
                   || ((paddr_q >> APP_ADDR_W) != '0)
                   || ((paddr_q & APB_ADDR_W'(APB_BYTES - 1)) != '0)
                   || (!pwrite_q && (drop_q == DROP_MAX));

  // app_en/wren are registered, so "done" means already low or handshaking now.
  assign en_done   = !app_en_o || app_rdy_i;
  assign wren_done = !app_wdf_wren_o || app_wdf_rdy_i;
  assign tmo       = cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1);
  assign beat_ok   = app_rd_data_valid_i && (drop_q == '0);
  assign discard   = app_rd_data_valid_i && (drop_q != '0);
  // A successful beat in the last allowed cycle wins over the timeout.
  assign lost_read = (state_q == S_RD_WAIT) && !beat_ok && tmo;
  assign issue     = (state_q == S_CHECK) && (state_d != S_RESP);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    resp_err = 1'b0;
    unique case (state_q)
      S_IDLE:    if (psel_i && !penable_i) state_d = S_CHECK;
      S_CHECK: begin
        if (check_err) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end else begin
          state_d = pwrite_q ? S_WR : S_RD_CMD;
        end
      end
      S_WR: begin
        if (en_done && wren_done) begin
          state_d = S_RESP;
        end else if (tmo) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end
      end
      S_RD_CMD: begin
        if (app_rdy_i) begin
          state_d = S_RD_WAIT;
        end else if (tmo) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (beat_ok) begin
          state_d = S_RESP;
        end else if (tmo) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mask_c = '1;
    mask_c[int'(lane)*APB_BYTES +: APB_BYTES] = ~pstrb_q;
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (preset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      paddr_q        <= '0;
      pwdata_q       <= '0;
      pstrb_q        <= '0;
      pwrite_q       <= 1'b0;
      cnt_q          <= '0;
      drop_q         <= '0;
      err_q          <= 1'b0;
      prdata_o       <= '0;
      app_addr_o     <= '0;
      app_cmd_o      <= CMD_WR;
      app_en_o       <= 1'b0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '0;
      app_wdf_wren_o <= 1'b0;
    end else begin
      if (state_q == S_IDLE && state_d == S_CHECK) begin
        paddr_q  <= paddr_i;
        pwdata_q <= pwdata_i;
        pstrb_q  <= pstrb_i;
        pwrite_q <= pwrite_i;
        prdata_o <= '0;   // error and timeout completions return zero
      end

      if (issue) begin
        cnt_q          <= '0;
        app_addr_o     <= paddr_q[APP_ADDR_W-1:0] & ~APP_ADDR_W'(APP_BYTES - 1);
        app_cmd_o      <= pwrite_q ? CMD_WR : CMD_RD;
        app_wdf_data_o <= {LANES{pwdata_q}};
        app_wdf_mask_o <= mask_c;
      end else if (state_q == S_WR || state_q == S_RD_CMD || state_q == S_RD_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Each strobe falls on its own handshake, or when the timeout abandons the transfer.
      app_en_o       <= issue ? 1'b1
                      : app_en_o && !app_rdy_i && (state_d == S_WR || state_d == S_RD_CMD);
      app_wdf_wren_o <= (issue && pwrite_q) ? 1'b1
                      : app_wdf_wren_o && !app_wdf_rdy_i && (state_d == S_WR);

      if (state_q == S_RD_WAIT && beat_ok)
        prdata_o <= app_rd_data_i[int'(lane)*APB_DATA_W +: APB_DATA_W];

      if (state_d == S_RESP) err_q <= resp_err;

      // Late beats of abandoned reads are counted and swallowed; saturation keeps
      // the count meaningful, and CHECK refuses new reads while saturated.
      unique case ({lost_read, discard})
        2'b10:   if (drop_q != DROP_MAX) drop_q <= drop_q + 1'b1;
        2'b01:   drop_q <= drop_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign pready_o      = (state_q == S_RESP);
  assign pslverr_o     = (state_q == S_RESP) && err_q;
  assign app_wdf_end_o = app_wdf_wren_o;

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Self-checking bench for apb_mig_bridge (APB 32 bit, MIG 128 bit, timeout 8 cycles).
// A behavioural MIG responder logs commands and returns read beats in order.
module tb_apb_mig_bridge;

  logic         clk = 1'b0;
  logic         preset;
  logic [31:0]  paddr, pwdata, prdata;
  logic         pwrite, psel, penable, pready, pslverr, calib;
  logic [3:0]   pstrb;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy, wren, wend, wdf_rdy, rd_valid;
  logic [127:0] wdf_data, rd_data;
  logic [15:0]  wdf_mask;

  int n_checks = 0;
  int n_fail   = 0;

  apb_mig_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .pclk_i(clk), .preset_i(preset),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel),
    .penable_i(penable), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .init_calib_complete_i(calib),
    .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
    .app_wdf_data_o(wdf_data), .app_wdf_mask_o(wdf_mask), .app_wdf_wren_o(wren),
    .app_wdf_end_o(wend), .app_wdf_rdy_i(wdf_rdy),
    .app_rd_data_i(rd_data), .app_rd_data_valid_i(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- MIG responder ----------------
  bit           cfg_rdy = 1, cfg_wdf_rdy = 1, cfg_rand = 0, cfg_fixed = 0;
  int           cfg_lat = 1;
  logic [127:0] cfg_data = '0;

  int           cyc = 0, last_due = 0, stall_a = 0, stall_w = 0;
  int           n_cmds = 0, en_cyc = 0, wren_cyc = 0, wend_bad = 0;
  int           rd_q_due[$];
  logic [127:0] rd_q_data[$];
  logic [127:0] last_rd_beat, last_wdata;
  logic [27:0]  last_addr;
  logic [2:0]   last_cmd;
  logic [15:0]  last_wmask;

  initial begin
    logic [127:0] d;
    int due;
    app_rdy = 0; wdf_rdy = 0; rd_valid = 0; rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (preset) begin
        app_rdy = 0; wdf_rdy = 0; rd_valid = 0;
        continue;
      end
      if (!cfg_rdy) app_rdy = 0;
      else if (cfg_rand && stall_a < 1 && $urandom_range(0, 1) == 0) begin app_rdy = 0; stall_a++; end
      else begin app_rdy = 1; stall_a = 0; end
      if (!cfg_wdf_rdy) wdf_rdy = 0;
      else if (cfg_rand && stall_w < 1 && $urandom_range(0, 1) == 0) begin wdf_rdy = 0; stall_w++; end
      else begin wdf_rdy = 1; stall_w = 0; end

      if (app_en) en_cyc++;
      if (wren) wren_cyc++;
      if (wend !== wren) wend_bad++;
      if (app_en && app_rdy) begin
        n_cmds++;
        last_addr = app_addr;
        last_cmd  = app_cmd;
        if (app_cmd == 3'b001) begin
          d = cfg_fixed ? cfg_data : {$urandom(), $urandom(), $urandom(), $urandom()};
          last_rd_beat = d;
          due = cyc + cfg_lat;
          if (due <= last_due) due = last_due + 1;   // MIG returns reads in order
          last_due = due;
          rd_q_due.push_back(due);
          rd_q_data.push_back(d);
        end
      end
      if (wren && wdf_rdy) begin
        last_wdata = wdf_data;
        last_wmask = wdf_mask;
      end
      if (rd_q_due.size() > 0 && rd_q_due[0] == cyc) begin
        rd_valid = 1;
        rd_data  = rd_q_data.pop_front();
        void'(rd_q_due.pop_front());
      end else begin
        rd_valid = 0;
        rd_data  = '0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [27:0] exp_addr(input logic [31:0] a);
    logic [27:0] b;
    b = a[27:0];
    return {b[27:4], 4'h0};
  endfunction

  function automatic logic [15:0] exp_mask(input logic [31:0] a, input logic [3:0] strb);
    int base;
    logic [15:0] m;
    base = ((a / 4) % 4) * 4;
    m = 16'hFFFF;
    for (int b = 0; b < 4; b++) if (strb[b]) m[base + b] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] exp_lane(input logic [127:0] beat, input logic [31:0] a);
    logic [127:0] s;
    s = beat >> (32 * ((a / 4) % 4));
    return s[31:0];
  endfunction

  // ---------------- checking / APB driver ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pready"},  pready,   1'b0);
    check({tag, "_pslverr"}, pslverr,  1'b0);
    check({tag, "_prdata"},  prdata,   32'h0);
    check({tag, "_app_en"},  app_en,   1'b0);
    check({tag, "_wren"},    wren,     1'b0);
    check({tag, "_wend"},    wend,     1'b0);
    check({tag, "_addr"},    app_addr, 28'h0);
    check({tag, "_wdata"},   wdf_data, 128'h0);
    check({tag, "_wmask"},   wdf_mask, 16'h0);
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] strb, output logic err, output logic [31:0] rd,
                     output int lat);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = strb;
    @(negedge clk);
    penable = 1;
    lat = 1;
    while (pready !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("pready_seen", pready, 1'b1);
    err = pslverr;
    rd  = prdata;
    @(negedge clk);
    psel = 0; penable = 0;
    check("pready_one_cycle", pready, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic        err, wr;
    logic [31:0] rd, a, r, wd;
    logic [3:0]  strb;
    int          lat, e0, w0, c0;

    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    calib = 1;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    preset = 0;

    // Write to lane 1 with two strobes, MIG always ready.
    apb(1'b1, 32'h14, 32'h1234_5678, 4'b0110, err, rd, lat);
    check("wr_err",   err, 1'b0);
    check("wr_lat",   lat, 3);
    check("wr_addr",  last_addr, exp_addr(32'h14));
    check("wr_cmd",   last_cmd, 3'b000);
    check("wr_data",  last_wdata, {4{32'h1234_5678}});
    check("wr_mask",  last_wmask, exp_mask(32'h14, 4'b0110));

    // Read lane 2 of a known beat with one-cycle MIG latency.
    cfg_fixed = 1;
    cfg_data  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    apb(1'b0, 32'h28, '0, '0, err, rd, lat);
    check("rd_err",  err, 1'b0);
    check("rd_lat",  lat, 4);
    check("rd_addr", last_addr, exp_addr(32'h28));
    check("rd_cmd",  last_cmd, 3'b001);
    check("rd_data", rd, exp_lane(cfg_data, 32'h28));
    cfg_fixed = 0;

    // Rejected transfers never reach the MIG.
    calib = 0; e0 = en_cyc; w0 = wren_cyc;
    apb(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, err, rd, lat);
    check("nocal_err", err, 1'b1);
    check("nocal_en",  en_cyc - e0, 0);
    check("nocal_wren", wren_cyc - w0, 0);
    calib = 1; e0 = en_cyc;
    apb(1'b0, 32'h1000_0040, '0, '0, err, rd, lat);
    check("range_err",  err, 1'b1);
    check("range_en",   en_cyc - e0, 0);
    check("range_data", rd, 32'h0);
    e0 = en_cyc;
    apb(1'b1, 32'h2, 32'h5555_AAAA, 4'hF, err, rd, lat);
    check("align_err", err, 1'b1);
    check("align_en",  en_cyc - e0, 0);

    // Write data never accepted: command goes, wren held for the timeout window.
    cfg_wdf_rdy = 0; c0 = n_cmds; w0 = wren_cyc;
    apb(1'b1, 32'h200, 32'h0BAD_BEEF, 4'hF, err, rd, lat);
    check("wtmo_err",  err, 1'b1);
    check("wtmo_cmds", n_cmds - c0, 1);
    check("wtmo_wren", wren_cyc - w0, 8);
    check("wtmo_lat",  lat, 10);
    cfg_wdf_rdy = 1;

    // Read times out after acceptance; its late beat must not feed the next read.
    cfg_lat = 14;
    apb(1'b0, 32'h300, '0, '0, err, rd, lat);
    check("rtmo_err",  err, 1'b1);
    check("rtmo_data", rd, 32'h0);
    cfg_lat = 3;
    apb(1'b0, 32'h304, '0, '0, err, rd, lat);
    check("late_err",  err, 1'b0);
    check("late_data", rd, exp_lane(last_rd_beat, 32'h304));

    // Random aligned traffic with short MIG stalls.
    cfg_rand = 1;
    for (int i = 0; i < 24; i++) begin
      r    = $urandom();
      a    = {4'h0, r[27:2], 2'b00};
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom();
      strb = 4'($urandom_range(0, 15));
      cfg_lat = $urandom_range(1, 3);
      apb(wr, a, wd, strb, err, rd, lat);
      check("rnd_err",  err, 1'b0);
      check("rnd_addr", last_addr, exp_addr(a));
      if (wr) begin
        check("rnd_wdata", last_wdata, {4{wd}});
        check("rnd_wmask", last_wmask, exp_mask(a, strb));
      end else begin
        check("rnd_rdata", rd, exp_lane(last_rd_beat, a));
      end
    end
    cfg_rand = 0;

    // Reset while waiting for read data, then a clean read.
    cfg_lat = 20;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h40;
    @(negedge clk);
    penable = 1;
    repeat (3) @(negedge clk);
    preset = 1;
    #1;
    rd_q_due.delete(); rd_q_data.delete(); last_due = 0;
    check_reset_vals("midrst");
    @(negedge clk);
    preset = 0; psel = 0; penable = 0;
    cfg_lat = 2;
    apb(1'b0, 32'h48, '0, '0, err, rd, lat);
    check("rst_rd_err",  err, 1'b0);
    check("rst_rd_data", rd, exp_lane(last_rd_beat, 32'h48));

    check("wdf_end_eq_wren", wend_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
